// File: rtl/frame_update_controller_pkg.sv
// Shared types and constants for the frame update controller: FSM encoding,
// register-file geometry and the display register map.
// No logic; no latency; no flow control.
package frame_update_controller_pkg;

    // Controller phases: accept writes, wait for frame gap, copy bank
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int NUM_REGS_DEFAULT = 16;
    localparam int REG_W            = 32;
    localparam int ADDR_W           = 4;

    // Display register map
    localparam int PIPE1X      = 0;
    localparam int PIPE2X      = 1;
    localparam int PIPE3X      = 2;
    localparam int PIPE4X      = 3;
    localparam int BOTTOMTOP1  = 4;
    localparam int BOTTOMTOP2  = 5;
    localparam int BOTTOMTOP3  = 6;
    localparam int BOTTOMTOP4  = 7;
    localparam int YSPACE1     = 8;
    localparam int YSPACE2     = 9;
    localparam int YSPACE3     = 10;
    localparam int YSPACE4     = 11;
    localparam int BIRD        = 12;
    localparam int CUR_SCORE   = 13;
    localparam int HI_SCORE    = 14;

    // True when a write address maps onto an implemented register; other
    // addresses are still handshaken but their data is dropped.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int num_regs);
        return ({{(32-ADDR_W){1'b0}}, addr} < 32'(num_regs));
    endfunction

endpackage

// File: rtl/frame_update_controller_sync.sv
// Two-flop synchronizer for an asynchronous button plus rising-edge detector.
// Latency: rise pulses in the 3rd cycle after the input edge (2 sync flops).
// No backpressure: rise is a single-cycle pulse with no handshake.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Shift the raw input through the sync chain and keep one cycle of history
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Edge is a synchronized high that was low one cycle earlier
    always_comb begin
        rise = sync2_q & ~prev_q;
    end

    // Synchronizer and history flops, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/frame_update_controller.sv
// Double-buffered display register file: CPU writes a pending bank, which is copied to the display bank between frames.
// Latency: commit lands on the edge after the first screenEnd following commit_req; game_active lags the display by 1 cycle.
// Backpressure: wr_ready is low from commit_req until the copy completes; jump_req is sticky until jump_ack.
module frame_update_controller
    import frame_update_controller_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEFAULT,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      screenEnd,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [REG_W-1:0]          wr_data,
    input  logic                      commit_req,
    output logic                      commit_done,
    output logic [NUM_REGS*REG_W-1:0] disp_regs,
    output logic                      game_active,
    input  logic                      jump,
    output logic                      jump_req,
    input  logic                      jump_ack,
    output logic [FRAME_CNT_W-1:0]    frame_count
);

    state_t state_q, state_d;

    logic [REG_W-1:0] pend_q [NUM_REGS];
    logic [REG_W-1:0] pend_d [NUM_REGS];
    logic [REG_W-1:0] disp_q [NUM_REGS];
    logic [REG_W-1:0] disp_d [NUM_REGS];

    logic                   game_active_q, game_active_d;
    logic                   jump_req_q,    jump_req_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    logic wr_fire;
    logic jump_rise;

    sync_edge_detect u_jump_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (jump),
        .rise     (jump_rise)
    );

    // Next-state and handshake outputs; a screenEnd seen while still IDLE
    // is ignored, so arming and the frame gap can never coincide.
    always_comb begin
        state_d     = state_q;
        wr_ready    = 1'b0;
        commit_done = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                if (commit_req) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (screenEnd) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit_done = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending bank takes accepted writes; out-of-range addresses are dropped
    always_comb begin
        wr_fire = wr_valid & wr_ready;
        pend_d  = pend_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_fire && addr_in_range(wr_addr, NUM_REGS)
                && ({{(32-ADDR_W){1'b0}}, wr_addr} == 32'(i))) begin
                pend_d[i] = wr_data;
            end
        end
    end

    // Display bank only moves on the edge leaving COMMIT, i.e. in the frame gap
    always_comb begin
        disp_d = disp_q;
        if (state_q == COMMIT) begin
            disp_d = pend_q;
        end
    end

    // Game is considered running once any displayed register is nonzero
    always_comb begin
        game_active_d = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (disp_q[i] != '0) begin
                game_active_d = 1'b1;
            end
        end
    end

    // Sticky jump flag: a fresh edge beats a simultaneous acknowledge
    always_comb begin
        jump_req_d = jump_req_q;
        if (jump_rise) begin
            jump_req_d = 1'b1;
        end else if (jump_ack) begin
            jump_req_d = 1'b0;
        end
    end

    // Free-running frame counter, wraps naturally
    always_comb begin
        frame_count_d = frame_count_q;
        if (screenEnd) begin
            frame_count_d = frame_count_q + FRAME_CNT_W'(1);
        end
    end

    // Flatten the display bank onto the output bus, register i at [32i +: 32]
    always_comb begin
        disp_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            disp_regs[i*REG_W +: REG_W] = disp_q[i];
        end
    end

    assign game_active = game_active_q;
    assign jump_req    = jump_req_q;
    assign frame_count = frame_count_q;

    // State registers; reset abandons any armed commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            game_active_q <= 1'b0;
            jump_req_q    <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
                disp_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            game_active_q <= game_active_d;
            jump_req_q    <= jump_req_d;
            frame_count_q <= frame_count_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= pend_d[i];
                disp_q[i] <= disp_d[i];
            end
        end
    end

endmodule

// File: tb/tb_frame_update_controller.sv
// Bench for frame_update_controller: directed scenarios plus random traffic.
// Expected display snapshots are queued at issue time and popped on commit_done.
// Runs with a 4-bit frame counter so wrap-around is reachable quickly.
module tb_frame_update_controller;

    localparam int NR = 16;
    localparam int FW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              screenEnd;
    logic              wr_valid;
    logic              wr_ready;
    logic [3:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              commit_req;
    logic              commit_done;
    logic [NR*32-1:0]  disp_regs;
    logic              game_active;
    logic              jump;
    logic              jump_req;
    logic              jump_ack;
    logic [FW-1:0]     frame_count;

    frame_update_controller #(.NUM_REGS(NR), .FRAME_CNT_W(FW)) dut (
        .clk         (clk),
        .reset       (reset),
        .screenEnd   (screenEnd),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .commit_done (commit_done),
        .disp_regs   (disp_regs),
        .game_active (game_active),
        .jump        (jump),
        .jump_req    (jump_req),
        .jump_ack    (jump_ack),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending bank contents, whether a commit has been
    // requested and is waiting for a frame gap, whether the copy happens now.
    logic [31:0]  m_pend [NR];
    bit           m_waiting;
    bit           m_copying;
    int           m_frames;
    int           commits_expected = 0;
    int           commits_seen = 0;
    logic [511:0] exp_q [$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] snapshot();
        logic [511:0] s;
        s = '0;
        for (int i = 0; i < NR; i++) s[i*32 +: 32] = m_pend[i];
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_pend[i] = '0;
        m_waiting = 1'b0;
        m_copying = 1'b0;
        m_frames  = 0;
        exp_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; outputs checked against the model, model advanced
    task automatic drive(input bit wv, input logic [3:0] wa, input logic [31:0] wd,
                         input bit cr, input bit se);
        wr_valid   = wv;
        wr_addr    = wa;
        wr_data    = wd;
        commit_req = cr;
        screenEnd  = se;
        chk("wr_ready", 512'(wr_ready), 512'(!(m_waiting || m_copying)));
        chk("commit_done", 512'(commit_done), 512'(m_copying));
        chk("frame_count", 512'(frame_count), 512'(m_frames % 16));
        if (m_copying) begin
            exp_q.push_back(snapshot());
            commits_expected++;
            m_copying = 1'b0;
        end else if (m_waiting) begin
            if (se) begin
                m_waiting = 1'b0;
                m_copying = 1'b1;
            end
        end else begin
            if (wv) m_pend[wa] = wd;
            if (cr) m_waiting = 1'b1;
        end
        if (se) m_frames = (m_frames + 1) % 16;
        step();
        wr_valid   = 1'b0;
        commit_req = 1'b0;
        screenEnd  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_clear();
        step();
        step();
        reset = 1'b0;
    endtask

    // Monitor: pops an expected snapshot on commit_done, compares the display
    // bank the cycle after, and otherwise insists the display bank is frozen.
    logic [511:0] prev_disp;
    logic [511:0] exp_snap;
    bit           compare_next = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_disp    = disp_regs;
            compare_next = 1'b0;
        end else begin
            if (compare_next) chk("disp_after_commit", disp_regs, exp_snap);
            else              chk("disp_stable", disp_regs, prev_disp);
            chk("game_active", 512'(game_active), 512'(prev_disp != '0));
            compare_next = 1'b0;
            if (commit_done) begin
                commits_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_commit_done: got 1 expected 0");
                end else begin
                    exp_snap     = exp_q.pop_front();
                    compare_next = 1'b1;
                end
            end
            prev_disp = disp_regs;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; screenEnd = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        commit_req = 1'b0; jump = 1'b0; jump_ack = 1'b0;
        model_clear();
        #3;
        chk("rst_wr_ready", 512'(wr_ready), 512'(1));
        chk("rst_disp", disp_regs, 512'(0));
        chk("rst_game_active", 512'(game_active), 512'(0));
        chk("rst_commit_done", 512'(commit_done), 512'(0));
        chk("rst_jump_req", 512'(jump_req), 512'(0));
        chk("rst_frame_count", 512'(frame_count), 512'(0));
        step();
        step();
        reset = 1'b0;

        // Jump path: 3-cycle set latency, ack clears, set beats ack
        jump = 1'b1;
        step(); chk("jump_c1", 512'(jump_req), 512'(0));
        step(); chk("jump_c2", 512'(jump_req), 512'(0));
        step(); chk("jump_c3", 512'(jump_req), 512'(1));
        step(); step();
        jump_ack = 1'b1;
        step(); jump_ack = 1'b0;
        chk("jump_ack_clear", 512'(jump_req), 512'(0));
        jump = 1'b0;
        repeat (4) step();
        jump = 1'b1;
        repeat (3) step();
        chk("jump_reset_again", 512'(jump_req), 512'(1));
        jump = 1'b0;
        repeat (4) step();
        chk("jump_sticky", 512'(jump_req), 512'(1));
        jump = 1'b1;
        step(); step();
        jump_ack = 1'b1;
        step(); jump_ack = 1'b0;
        chk("jump_set_wins", 512'(jump_req), 512'(1));
        step();
        chk("jump_hold", 512'(jump_req), 512'(1));

        // Single register write and commit 10 cycles later
        drive(1'b1, 4'd0, 32'h0000_0064, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        idle(9);
        chk("disp0_before_commit", 512'(disp_regs[31:0]), 512'(0));
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(1);
        chk("disp0_after_commit", 512'(disp_regs[31:0]), 512'(32'h64));
        chk("game_active_lag", 512'(game_active), 512'(0));
        idle(1);
        chk("game_active_set", 512'(game_active), 512'(1));
        chk("one_commit", 512'(commits_seen), 512'(1));

        // commit_req and screenEnd together: only the next screenEnd commits
        drive(1'b1, 4'd13, 32'h0000_0007, 1'b1, 1'b1);
        idle(3);
        chk("no_early_commit", 512'(commits_seen), 512'(1));
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(2);
        chk("score_committed", 512'(disp_regs[13*32 +: 32]), 512'(32'h7));

        // Writes held off while ARMED, accepted once back in IDLE
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 4'd3, 32'h0000_00AB, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 32'h0000_00AB, 1'b0, 1'b1);
        drive(1'b1, 4'd3, 32'h0000_00AB, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 32'h0000_00AB, 1'b0, 1'b0);
        chk("held_write_not_in_disp", 512'(disp_regs[3*32 +: 32]), 512'(0));
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(2);
        chk("held_write_committed", 512'(disp_regs[3*32 +: 32]), 512'(32'hAB));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
        end
        repeat (3) drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(2);

        // Reset while ARMED abandons the commit; a write during reset is lost
        drive(1'b1, 4'd5, 32'h1234_5678, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        chk("armed_wr_ready", 512'(wr_ready), 512'(0));
        chk("disp_nonzero_pre_reset", 512'(disp_regs != '0), 512'(1));
        reset = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_DEAD;
        #1;
        chk("armed_rst_disp", disp_regs, 512'(0));
        chk("armed_rst_game_active", 512'(game_active), 512'(0));
        chk("armed_rst_jump_req", 512'(jump_req), 512'(0));
        chk("armed_rst_frame_count", 512'(frame_count), 512'(0));
        chk("armed_rst_wr_ready", 512'(wr_ready), 512'(1));
        model_clear();
        step();
        step();
        reset = 1'b0;
        wr_valid = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(3);
        chk("no_commit_after_reset", disp_regs, 512'(0));
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(2);
        chk("write_during_reset_lost", 512'(disp_regs[7*32 +: 32]), 512'(0));

        // 4-bit frame counter wraps: 17 pulses leave it at 1
        apply_reset();
        for (int k = 0; k < 17; k++) drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        chk("frame_count_wrap", 512'(frame_count), 512'(1));

        idle(4);
        chk("queue_drained", 512'(exp_q.size()), 512'(0));
        chk("commit_count", 512'(commits_seen), 512'(commits_expected));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_update_controller.md
FRAME_UPDATE_CONTROLLER -- requirements
Module: frame_update_controller

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit display registers (pipe x/bottomtop/yspace, bird, scores).
REQ-002 SHALL have parameter FRAME_CNT_W, default 16, frame counter width.
REQ-003 SHALL have port clk  in  1  100 MHz system clock; the block has one clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port screenEnd  in  1  one-cycle pulse between frames, from the timing generator.
REQ-006 SHALL have port wr_valid  in  1  processor register write request.
REQ-007 SHALL have port wr_ready  out  1  write accepted when wr_valid and wr_ready are both high.
REQ-008 SHALL have port wr_addr  in  4  pending-bank register index.
REQ-009 SHALL have port wr_data  in  32  write data.
REQ-010 SHALL have port commit_req  in  1  pulse requesting pending-to-display copy.
REQ-011 SHALL have port commit_done  out  1  one-cycle pulse when the copy completes.
REQ-012 SHALL have port disp_regs  out  NUM_REGS*32  display bank, register i at bits [32i+31:32i].
REQ-013 SHALL have port game_active  out  1  registered; high when any display register is nonzero.
REQ-014 SHALL have port jump  in  1  raw asynchronous button.
REQ-015 SHALL have port jump_req  out  1  sticky jump flag.
REQ-016 SHALL have port jump_ack  in  1  clears jump_req.
REQ-017 SHALL have port frame_count  out  FRAME_CNT_W  count of screenEnd pulses.

Function
REQ-018 SHALL use FSM states IDLE, ARMED, COMMIT.
REQ-019 IDLE: wr_ready=1; an accepted write updates pending[wr_addr] on that clock edge; commit_req moves the FSM to ARMED.
REQ-020 ARMED: wr_ready=0; screenEnd moves the FSM to COMMIT; commit_req is ignored.
REQ-021 A screenEnd in the same cycle as the IDLE->ARMED transition SHALL NOT trigger a commit; the next screenEnd does.
REQ-022 COMMIT (one cycle): all pending registers copy to the display bank on the exiting edge; commit_done=1 for that cycle; the FSM then returns to IDLE.
REQ-023 disp_regs SHALL change only on the COMMIT exit edge, so no mid-frame tearing occurs.
REQ-024 A write and commit_req in the same IDLE cycle SHALL accept the write, and that write SHALL be included in the commit.
REQ-025 game_active SHALL be registered from the display bank, lagging disp_regs by 1 cycle.
REQ-026 jump SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal sets jump_req, giving 3-cycle latency from the jump edge to jump_req.
REQ-027 jump_ack SHALL clear jump_req; on a simultaneous new edge and jump_ack, the set SHALL win.
REQ-028 frame_count SHALL increment on each screenEnd and wrap from all-ones to 0.
REQ-029 wr_addr values >= NUM_REGS SHALL be accepted and discarded.

Reset
REQ-030 While reset is high, all state SHALL be forced asynchronously: FSM=IDLE, pending and display banks 0, game_active=0, jump_req=0, synchronizer flops 0, frame_count=0, commit_done=0.
REQ-031 wr_ready SHALL be 1 during reset; a write that coincides with reset is lost.
REQ-032 A reset asserted while ARMED SHALL abandon the commit, and no commit_done SHALL be issued.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, the NUM_REGS default, and register index constants (PIPE1X=0..PIPE4X=3, BOTTOMTOP 4-7, YSPACE 8-11, BIRD=12, CUR_SCORE=13, HI_SCORE=14).
REQ-034 The jump synchronizer and edge detector SHALL be one sub-module, named sync_edge_detect.

Verification
REQ-035 Reset, write 0x00000064 to addr 0, commit_req, screenEnd after 10 cycles -> disp_regs[31:0] stays 0 until the COMMIT edge, then equals 0x64; commit_done pulses once; game_active=1 one cycle later.
REQ-036 commit_req and screenEnd in the same cycle -> no commit; the commit occurs at the following screenEnd.
REQ-037 While ARMED, wr_valid held with addr 3, data 0xAB -> wr_ready=0, no write is accepted; the write is accepted in the first IDLE cycle after COMMIT.
REQ-038 jump rising edge at cycle 0 -> jump_req=1 at cycle 3; jump_ack at cycle 5 -> jump_req=0 at cycle 6; a new edge coinciding with jump_ack -> jump_req stays 1.
REQ-039 FRAME_CNT_W=4, 17 screenEnd pulses -> frame_count=1.
REQ-040 Reset asserted while ARMED -> outputs cleared immediately; no commit_done after reset release; the next screenEnd does not alter disp_regs.
